softmax_bram_seq: RTL and testbench
===================================

SOFTMAX_BRAM_SEQ -- requirements
Module: softmax_bram_seq

Interface
REQ-001 SHALL provide parameter DATA_W, default 1024, width of the feature/probability vector.
REQ-002 SHALL provide parameter MODE_W, default 4, width of the length-mode field stored above the data in each BRAM word.
REQ-003 SHALL provide parameter ADDR_W, default 5, BRAM address width.
REQ-004 SHALL provide parameter RD_LAT, default 2, BRAM read latency in cycles, legal range 1-4.
REQ-005 SHALL provide parameter TAG_DEPTH, default 16, mode-tag FIFO depth, power of two.
REQ-006 Ports, one per line (name, direction, width, meaning):
 i_clk  in  1  sole clock, rising edge
 i_rst  in  1  synchronous reset, active-high
 i_en  in  1  global clock enable; low freezes every register
 i_start  in  1  start pulse
 i_num_rows  in  ADDR_W+1  rows to process, sampled on accepted start
 i_src_base  in  ADDR_W  first read address, sampled on accepted start
 i_dst_base  in  ADDR_W  first write address, sampled on accepted start
 o_busy  out  1  job in progress
 o_done  out  1  one-cycle pulse at job completion
 o_err  out  1  sticky protocol error
 o_cena  out  1  port A enable
 o_wea  out  1  port A write enable
 o_addra  out  ADDR_W  port A address
 o_dina  out  MODE_W+DATA_W  port A write data
 o_cenb  out  1  port B enable
 o_addrb  out  ADDR_W  port B address
 i_doutb  in  MODE_W+DATA_W  port B read data
 o_valid  out  1  input-vector valid to softmax
 o_length_mode  out  MODE_W  mode for the current vector
 o_in_x_flat  out  DATA_W  feature vector
 i_valid  in  1  softmax result valid
 i_prob_flat  in  DATA_W  softmax result

Function
REQ-007 All register updates SHALL occur only when i_en=1; i_en=0 holds every register and output.
REQ-008 Control FSM SHALL have states IDLE, READ, DRAIN, DONE.
REQ-009 IDLE: i_start=1 with i_num_rows>0 SHALL latch num_rows/src_base/dst_base, clear o_err, set o_busy=1, go READ.
REQ-010 IDLE: i_start=1 with i_num_rows=0 SHALL go DONE directly with no BRAM access.
REQ-011 i_start outside IDLE SHALL be ignored.
REQ-012 READ: each cycle SHALL assert o_cenb=1, o_addrb=(src_base+rd_idx) mod 2^ADDR_W, rd_idx incrementing by 1; after rd_idx=num_rows-1 go DRAIN, o_cenb=0 next cycle.
REQ-013 o_valid SHALL equal the o_cenb issue flag delayed RD_LAT cycles; o_length_mode/o_in_x_flat SHALL be i_doutb[MODE_W+DATA_W-1:DATA_W] / i_doutb[DATA_W-1:0] combinationally.
REQ-014 Every o_valid cycle SHALL push o_length_mode into the in-order tag FIFO; num_rows>TAG_DEPTH is legal only if softmax drains fast enough; push while full SHALL set o_err and drop the tag.
REQ-015 Every i_valid cycle while busy SHALL pop one tag; the next cycle SHALL assert o_cena=o_wea=1, o_addra=(dst_base+wr_idx) mod 2^ADDR_W, o_dina={popped tag, i_prob_flat registered}, then wr_idx+1.
REQ-016 Results MAY arrive non-contiguously; gaps SHALL produce o_cena=o_wea=0.
REQ-017 i_valid with empty tag FIFO, or while not busy, SHALL set o_err and SHALL NOT write.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; pop of a tag pushed the same cycle is not required (FIFO read-before-write).
REQ-019 DRAIN SHALL wait until wr_idx=num_rows and final write issued, then go DONE.
REQ-020 DONE SHALL pulse o_done=1 for one cycle, set o_busy=0, return to IDLE.
REQ-021 Read and write address counters SHALL wrap modulo 2^ADDR_W without error.

Reset
REQ-022 i_rst=1 (sampled regardless of i_en) SHALL force IDLE, clear indices, pipeline, tag FIFO, and all outputs to 0 (o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid, o_addra, o_addrb, o_dina registered part).
REQ-023 Reset mid-job SHALL abort with no o_done pulse and no further BRAM writes.

Verification
REQ-024 Defaults, start num_rows=12 src=0 dst=12, softmax latency 5 -> reads 0..11 on consecutive cycles, o_valid 2 cycles after each, writes 12..23 with matching modes, one o_done, o_err=0.
REQ-025 num_rows=0 start -> o_done pulse 1 cycle later, no o_cenb/o_cena activity.
REQ-026 src=30 num_rows=4 -> o_addrb 30,31,0,1; dst=31 -> o_addra 31,0,1,2.
REQ-027 Softmax returns results with random gaps, i_en toggled randomly -> write data/addresses identical to gap-free run, o_busy held throughout.
REQ-028 Spurious i_valid in IDLE -> o_err=1, no write; next accepted start clears o_err.
REQ-029 i_rst during READ at rd_idx=5 -> all outputs 0 next cycle, no o_done, subsequent job runs correctly.

Source files
------------

// File: rtl/softmax_bram_seq.sv
// rtl/softmax_bram_seq.sv - BRAM-to-softmax job sequencer with in-order mode-tag FIFO
// Streams rows from BRAM port B into softmax and writes tagged results back through port A.
module softmax_bram_seq #(
  parameter int DATA_W    = 1024,
  parameter int MODE_W    = 4,
  parameter int ADDR_W    = 5,
  parameter int RD_LAT    = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_start,
  input  logic [ADDR_W:0]          i_num_rows,
  input  logic [ADDR_W-1:0]        i_src_base,
  input  logic [ADDR_W-1:0]        i_dst_base,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic                     o_cena,
  output logic                     o_wea,
  output logic [ADDR_W-1:0]        o_addra,
  output logic [MODE_W+DATA_W-1:0] o_dina,
  output logic                     o_cenb,
  output logic [ADDR_W-1:0]        o_addrb,
  input  logic [MODE_W+DATA_W-1:0] i_doutb,
  output logic                     o_valid,
  output logic [MODE_W-1:0]        o_length_mode,
  output logic [DATA_W-1:0]        o_in_x_flat,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_prob_flat
);
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam logic [TAG_AW:0]   TAG_FULL = (TAG_AW+1)'(TAG_DEPTH);
  localparam logic [ADDR_W:0]   ROW_ONE  = (ADDR_W+1)'(1);
  localparam logic [TAG_AW-1:0] PTR_ONE  = TAG_AW'(1);
  localparam logic [TAG_AW:0]   CNT_ONE  = (TAG_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W:0]   num_rows, rd_idx, wr_idx;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic [RD_LAT-1:0] vld_pipe;
  logic [MODE_W-1:0] tag_mem [TAG_DEPTH];
  logic [TAG_AW-1:0] tag_wptr, tag_rptr;
  logic [TAG_AW:0]   tag_cnt;
  logic              tag_full, tag_empty, push_ok, pop, err_evt, accept, wr_pend;

  assign accept    = (state == IDLE) && i_start && (i_num_rows != '0);
  assign tag_full  = (tag_cnt == TAG_FULL);
  assign tag_empty = (tag_cnt == '0);
  assign push_ok   = o_valid && !tag_full;
  // Tag FIFO is read-before-write: a pop only ever sees tags pushed on earlier cycles.
  assign pop       = i_valid && o_busy && !tag_empty;
  assign err_evt   = (o_valid && tag_full) || (i_valid && !pop);

  assign o_valid       = vld_pipe[RD_LAT-1];
  assign o_length_mode = i_doutb[MODE_W+DATA_W-1:DATA_W];
  assign o_in_x_flat   = i_doutb[DATA_W-1:0];
  assign o_addrb       = o_cenb ? (src_base + rd_idx[ADDR_W-1:0]) : '0;
  assign o_cena        = wr_pend;
  assign o_wea         = wr_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst)     state <= IDLE;
    else if (i_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_cenb    = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE:  if (i_start) state_nxt = (i_num_rows != '0) ? READ : DONE;
      READ: begin
        o_cenb = 1'b1;
        o_busy = 1'b1;
        if (rd_idx == num_rows - ROW_ONE) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        // The last write is on port A in the same cycle wr_idx reaches num_rows.
        if (wr_idx == num_rows) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num_rows <= '0;
      src_base <= '0;
      dst_base <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      vld_pipe <= '0;
      tag_wptr <= '0;
      tag_rptr <= '0;
      tag_cnt  <= '0;
      wr_pend  <= 1'b0;
      o_addra  <= '0;
      o_dina   <= '0;
      o_err    <= 1'b0;
    end else if (i_en) begin
      if (accept) begin
        num_rows <= i_num_rows;
        src_base <= i_src_base;
        dst_base <= i_dst_base;
        rd_idx   <= '0;
        wr_idx   <= '0;
      end else begin
        if (state == READ) rd_idx <= rd_idx + ROW_ONE;
        if (pop)           wr_idx <= wr_idx + ROW_ONE;
      end
      o_err <= (o_err && !accept) || err_evt;

      vld_pipe[0] <= o_cenb;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

      if (push_ok) tag_wptr <= tag_wptr + PTR_ONE;
      if (pop)     tag_rptr <= tag_rptr + PTR_ONE;
      if (push_ok && !pop)      tag_cnt <= tag_cnt + CNT_ONE;
      else if (!push_ok && pop) tag_cnt <= tag_cnt - CNT_ONE;

      wr_pend <= pop;
      if (pop) begin
        o_addra <= dst_base + wr_idx[ADDR_W-1:0];
        o_dina  <= {tag_mem[tag_rptr], i_prob_flat};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en && push_ok) tag_mem[tag_wptr] <= o_length_mode;
  end
endmodule

// File: tb/tb_softmax_bram_seq.sv
// tb/tb_softmax_bram_seq.sv - self-checking bench for softmax_bram_seq
// BRAM and softmax models drive the DUT; expected reads/writes are queued at job start.
module tb_softmax_bram_seq;
  localparam int DW = 1024, MW = 4, AW = 5, RL = 2, WW = DW + MW, SM_LAT = 5;

  logic          i_clk = 1'b0, i_rst, i_en, i_start, i_valid;
  logic [AW:0]   i_num_rows;
  logic [AW-1:0] i_src_base, i_dst_base, o_addra, o_addrb;
  logic          o_busy, o_done, o_err, o_cena, o_wea, o_cenb, o_valid;
  logic [WW-1:0] o_dina, i_doutb;
  logic [MW-1:0] o_length_mode;
  logic [DW-1:0] o_in_x_flat, i_prob_flat;

  softmax_bram_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_start(i_start),
    .i_num_rows(i_num_rows), .i_src_base(i_src_base), .i_dst_base(i_dst_base),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_cena(o_cena), .o_wea(o_wea), .o_addra(o_addra), .o_dina(o_dina),
    .o_cenb(o_cenb), .o_addrb(o_addrb), .i_doutb(i_doutb),
    .o_valid(o_valid), .o_length_mode(o_length_mode), .o_in_x_flat(o_in_x_flat),
    .i_valid(i_valid), .i_prob_flat(i_prob_flat)
  );

  initial forever #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;
  int cyc = 0, en_cyc = 0, done_cnt = 0;
  bit rand_en = 1'b0, gaps = 1'b0, sm_off = 1'b0;
  logic [WW-1:0] mem [32];
  logic [AW-1:0] ap0 = '0, ap1 = '0;
  logic [AW-1:0] exp_rd_addr[$], exp_wr_addr[$];
  logic [WW-1:0] exp_wr_data[$];
  logic [DW-1:0] sm_x[$];
  int            sm_t[$], rd_t[$];

  // BRAM read port shares the global enable with the sequencer.
  always @(posedge i_clk) if (i_en) begin
    ap0 <= o_addrb;
    ap1 <= ap0;
  end
  assign i_doutb = mem[ap1];

  function automatic logic [DW-1:0] soft_f(input logic [DW-1:0] x);
    return x ^ {32{32'hC35A_96E1}};
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h..%h expected=%h..%h", tag, obs[WW-1 -: 16], obs[63:0], exp[WW-1 -: 16], exp[63:0]);
    end
  endtask

  // Per-cycle environment: decides enable, models softmax, checks port traffic on enabled edges.
  initial forever begin
    @(negedge i_clk);
    cyc++;
    i_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (i_en) begin
      if (o_valid) begin
        check("valid_expected", rd_t.size() != 0, 1);
        if (rd_t.size() != 0) check("valid_latency", en_cyc - rd_t.pop_front(), RL);
        sm_x.push_back(o_in_x_flat);
        sm_t.push_back(cyc);
      end
      if (o_cenb) begin
        check("read_expected", exp_rd_addr.size() != 0, 1);
        if (exp_rd_addr.size() != 0) check("read_addr", o_addrb, exp_rd_addr.pop_front());
        rd_t.push_back(en_cyc);
      end
      if (o_cena) begin
        check("write_wea", o_wea, 1);
        check("write_expected", exp_wr_addr.size() != 0, 1);
        if (exp_wr_addr.size() != 0) begin
          check("write_addr", o_addra, exp_wr_addr.pop_front());
          check("write_data", o_dina, exp_wr_data.pop_front());
        end
      end
      if (o_done) done_cnt++;
      en_cyc++;
    end
    if (!sm_off) begin
      if (i_en && sm_x.size() > 0 && cyc - sm_t[0] >= SM_LAT && (!gaps || $urandom_range(0, 2) == 0)) begin
        i_valid     = 1'b1;
        i_prob_flat = soft_f(sm_x.pop_front());
        void'(sm_t.pop_front());
      end else begin
        i_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
    #2;
  endtask

  task automatic start_job(input int n, input int src, input int dst);
    logic [WW-1:0] w;
    int k;
    for (int i = 0; i < n; i++) begin
      w = mem[AW'(src + i)];
      exp_rd_addr.push_back(AW'(src + i));
      exp_wr_addr.push_back(AW'(dst + i));
      exp_wr_data.push_back({w[WW-1:DW], soft_f(w[DW-1:0])});
    end
    i_num_rows = (AW+1)'(n);
    i_src_base = AW'(src);
    i_dst_base = AW'(dst);
    i_start    = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!o_busy && k < 50);
    check("start_busy", o_busy, 1);
    i_start = 1'b0;
  endtask

  task automatic wait_done();
    int k, d0;
    k  = 0;
    d0 = done_cnt;
    while (!o_done && k < 3000) begin
      check("busy_held", o_busy, 1);
      tick();
      k++;
    end
    check("done_seen", o_done, 1);
    check("done_busy_low", o_busy, 0);
    repeat (4) tick();
    check("done_once", done_cnt - d0, 1);
    check("reads_all", exp_rd_addr.size(), 0);
    check("writes_all", exp_wr_addr.size(), 0);
    check("err_clear", o_err, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_cena"}, o_cena, 0);
    check({tag, "_wea"}, o_wea, 0);
    check({tag, "_cenb"}, o_cenb, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_addra"}, o_addra, 0);
    check({tag, "_addrb"}, o_addrb, 0);
    check({tag, "_dina"}, o_dina, 0);
  endtask

  initial begin
    logic [WW-1:0] w;
    int k, d0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = $urandom;
      w[WW-1 -: MW] = MW'($urandom_range(0, 15));
      mem[i] = w;
    end
    i_rst = 1'b1; i_en = 1'b1; i_start = 1'b0; i_valid = 1'b0;
    i_num_rows = '0; i_src_base = '0; i_dst_base = '0; i_prob_flat = '0;
    repeat (3) tick();
    check_zero("reset");
    i_rst = 1'b0;
    tick();

    // Basic 12-row job, results gap-free
    start_job(12, 0, 12);
    wait_done();

    // Zero-row job: done one cycle later, no BRAM traffic
    i_num_rows = '0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("zero_done", o_done, 1);
    check("zero_busy", o_busy, 0);
    tick();
    check("zero_done_end", o_done, 0);

    // Address wrap on both ports
    start_job(4, 30, 31);
    wait_done();

    // Random result gaps and random enable; same expected traffic as the gap-free job
    gaps = 1'b1; rand_en = 1'b1;
    start_job(12, 0, 12);
    wait_done();
    gaps = 1'b0; rand_en = 1'b0;
    tick();

    // Spurious result while idle
    sm_off = 1'b1;
    i_valid = 1'b1;
    tick();
    check("spurious_err", o_err, 1);
    check("spurious_nowrite", o_cena, 0);
    i_valid = 1'b0;
    sm_off = 1'b0;
    tick();
    start_job(5, 7, 20);
    check("start_clears_err", o_err, 0);
    wait_done();

    // Reset while reading row 5
    start_job(12, 3, 16);
    k = 0;
    while (!(o_cenb && o_addrb == AW'(8)) && k < 20) begin
      tick();
      k++;
    end
    check("reached_row5", o_addrb, AW'(8));
    i_rst = 1'b1;
    exp_rd_addr.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
    sm_x.delete(); sm_t.delete(); rd_t.delete();
    d0 = done_cnt;
    tick();
    check_zero("midreset");
    i_rst = 1'b0;
    repeat (20) tick();
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_no_err", o_err, 0);
    start_job(12, 0, 12);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
